mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative multiply/divide unit with architectural HI/LO registers for the basic MIPS core. It sits directly downstream of the register file: it consumes the two register read ports (rs, rt) for MULT/MULTU/DIV/DIVU, and its `hi`/`lo` outputs feed the writeback mux for MFHI/MFLO. The core stalls on `busy`. One 32-step shift-add / restoring-divide engine is shared by all four operations.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  launch request; sampled only in IDLE.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `src_a`  in  WIDTH  rs value; multiplicand or dividend.
- `src_b`  in  WIDTH  rt value; multiplier or divisor.
- `mthi_en`  in  1  write `wr_data` to HI (MTHI).
- `mtlo_en`  in  1  write `wr_data` to LO (MTLO).
- `wr_data`  in  WIDTH  data for MTHI/MTLO.
- `busy`  out  1  operation in flight; core must stall.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result.
- `div_by_zero`  out  1  one-cycle pulse with `done` when the divisor was 0.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- FSM states: IDLE, PREP, CALC, FIX.
- IDLE -> PREP when `start`=1.
  - Latch `op`, `src_a`, `src_b`, and the sign flags.
  - Operands may change after the accepting edge.
- PREP -> CALC.
  - Signed ops take absolute values of both operands.
  - Counter loaded with WIDTH-1.
- CALC performs one iteration per cycle; it moves to FIX when the counter is 0 at the edge.
  - Multiply: shift-add, 2*WIDTH-bit unsigned product.
  - Divide: restoring, unsigned quotient and remainder.
- FIX -> IDLE. Results are written to HI/LO at this edge.
  - MULT/MULTU: {HI,LO} = product. MULT negates the 64-bit product when the operand signs differ.
  - DIV/DIVU: LO = quotient, HI = remainder. DIV negates the quotient when the signs differ; the remainder takes the dividend's sign.
  - Also at this edge: `done`<=1, and `div_by_zero`<=1 if this was a zero-divisor divide.
- Divisor 0 (DIV or DIVU): LO = all ones, HI = original `src_a`. The engine still runs the full latency.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. This is the natural outcome of the abs/negate path.
- `start` while not in IDLE: ignored.
- `mthi_en`/`mtlo_en`:
  - Applied at the edge only when in IDLE and `start`=0.
  - Ignored while busy or when `start`=1 (start has priority).
  - Both may be asserted in the same cycle.
- `hi`/`lo` change only on a FIX edge or on an accepted MT write.

## Timing
- Reset (asynchronous, any state): FSM to IDLE, counter 0, `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_by_zero`=0.
  - Reset mid-operation discards the operation; no `done` is produced.
- `busy`:
  - Registered.
  - Rises on the accepting edge E0.
  - Falls on edge E34, the FIX edge.
- Edge timeline: E1 PREP->CALC; E2..E33 are the 32 iterations; E34 is FIX.
- `done` is high exactly during the cycle after E34. Result latency is 34 edges from acceptance.
- Back-to-back: a `start` sampled in the `done` cycle is accepted. Its own `done` follows 34 edges later.
- An MT write in IDLE is visible on `hi`/`lo` the cycle after its edge.

## Structure
- Shared package `mips_pkg` holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - the FSM state enum.
  - the localparam for the iteration count (WIDTH).
- One sub-module is natural: `md_sign_fix`. It is combinational conditional two's-complement negate of the 64-bit product, or of the quotient and remainder, and is used in FIX.
- FSM, counter, iteration datapath and HI/LO registers live in `mult_div_unit`.

## Test plan
- **MULTU:** 0xFFFFFFFF × 0xFFFFFFFF -> `done` 34 edges after acceptance; HI=0xFFFFFFFE, LO=0x00000001; `busy` high for exactly 34 cycles.
- **MULT and DIV signs:**
  - MULT -3 × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- **DIVU by zero:** 100 / 0 -> LO=0xFFFFFFFF, HI=100; `div_by_zero` and `done` pulse together.
- **DIV overflow:** 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- **MT writes:**
  - MTHI 0x1234 in IDLE -> `hi`=0x1234 next cycle.
  - MTLO or `start` asserted during `busy` -> no effect.
  - Back-to-back MULTU 2×3 then 4×5 with the second `start` in the `done` cycle -> LO=6, then LO=20 with HI=0, with `done` pulses 34 edges apart.
- **Reset mid-operation:** assert `rst_n`=0 at iteration 10 -> all outputs 0 immediately with no clock edge; no `done`; the next `start` runs normally.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multiply/divide unit:
// op encodings, FSM state type and the default operand width.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PREP = 2'b01,
    S_CALC = 2'b10,
    S_FIX  = 2'b11
  } md_state_e;

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement fix-up of the unsigned engine result.
// Ports: acc_i (64-bit product or {rem,quo}), is_div_i, neg_res_i, neg_rem_i -> hi_o, lo_o.
module md_sign_fix #(
  parameter int W = 32
) (
  input  logic [2*W-1:0] acc_i,
  input  logic           is_div_i,
  input  logic           neg_res_i,
  input  logic           neg_rem_i,
  output logic [W-1:0]   hi_o,
  output logic [W-1:0]   lo_o
);

  logic [2*W-1:0] prod;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;

  assign prod = neg_res_i ? -acc_i : acc_i;
  assign quo  = neg_res_i ? -acc_i[W-1:0] : acc_i[W-1:0];
  // Remainder follows the dividend's sign.
  assign rem  = neg_rem_i ? -acc_i[2*W-1:W] : acc_i[2*W-1:W];

  assign hi_o = is_div_i ? rem : prod[2*W-1:W];
  assign lo_o = is_div_i ? quo : prod[W-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-step multiply/divide unit with architectural HI/LO.
// Ports: clk, rst_n, start/op/src_a/src_b launch, mthi_en/mtlo_en/wr_data
// MT writes; busy, done, div_by_zero status; hi, lo registers.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mthi_en,
  input  logic             mtlo_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sa_q, sb_q;
  logic             accept;
  logic             sgn_op;

  logic             is_div;
  logic             b_zero;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh, div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] fix_hi, fix_lo;

  assign accept = (state_q == S_IDLE) && start;
  assign sgn_op = ~op[0];
  assign is_div = op_q[1];
  assign b_zero = (b_q == '0);

  // Sign flags are only set for signed ops, so abs is a no-op otherwise.
  assign a_abs = sa_q ? -a_q : a_q;
  assign b_abs = sb_q ? -b_q : b_q;

  // Shift-add step: multiplier in acc low half, product grows from the top.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, b_abs} : '0);

  // Restoring step: remainder in acc high half, dividend/quotient in low.
  assign div_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge  = div_sh >= {1'b0, b_abs};
  assign div_sub = div_sh - {1'b0, b_abs};
  assign rem_n   = div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0];

  md_sign_fix #(.W(WIDTH)) u_fix (
    .acc_i     (acc_q),
    .is_div_i  (is_div),
    .neg_res_i (sa_q ^ sb_q),
    .neg_rem_i (sa_q),
    .hi_o      (fix_hi),
    .lo_o      (fix_lo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PREP;
          busy_d  = 1'b1;
        end else begin
          if (mthi_en) hi_d = wr_data;
          if (mtlo_en) lo_d = wr_data;
        end
      end
      S_PREP: begin
        acc_d   = {{WIDTH{1'b0}}, a_abs};
        cnt_d   = CW'(WIDTH - 1);
        state_d = S_CALC;
      end
      S_CALC: begin
        if (is_div)
          acc_d = {rem_n, acc_q[WIDTH-2:0], div_ge};
        else
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        if (cnt_q == '0) state_d = S_FIX;
        else cnt_d = cnt_q - 1'b1;
      end
      S_FIX: begin
        if (is_div && b_zero) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = fix_hi;
          lo_d = fix_lo;
        end
        done_d  = 1'b1;
        dbz_d   = is_div && b_zero;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  // Operand capture; the core may change rs/rt after the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= OP_MULT;
      a_q  <= '0;
      b_q  <= '0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
    end else if (accept) begin
      op_q <= op;
      a_q  <= src_a;
      b_q  <= src_b;
      sa_q <= sgn_op & src_a[WIDTH-1];
      sb_q <= sgn_op & src_b[WIDTH-1];
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed ops push expected HI/LO,
// a negedge monitor pops and checks on every done pulse.
module tb_mult_div_unit;
  import mips_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         mthi_en = 1'b0;
  logic         mtlo_en = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .mthi_en     (mthi_en),
    .mtlo_en     (mtlo_en),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           acc;
    string        name;
  } exp_t;

  exp_t sb_q[$];
  int vectors = 0;
  int miscompares = 0;
  int busy_run = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (div_by_zero && !done) chk("dbz_without_done", 64'd1, 64'd0);
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk({e.name, "_hi"}, 64'(hi), 64'(e.hi));
          chk({e.name, "_lo"}, 64'(lo), 64'(e.lo));
          chk({e.name, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
          chk({e.name, "_latency"}, 64'(cyc - e.acc), 64'd34);
          chk({e.name, "_busy_cycles"}, 64'(busy_run), 64'd34);
        end
        busy_run = 0;
      end
    end
  end

  // Called at a negedge with the unit idle; leaves just after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] ehi,
                       input logic [W-1:0] elo, input logic edbz,
                       input string name, input bit expect_done);
    exp_t e;
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    if (expect_done) begin
      e.hi = ehi; e.lo = elo; e.dbz = edbz;
      e.acc = cyc + 1; e.name = name;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    src_a = $urandom;
    src_b = $urandom;
    op    = 2'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      chk("drain_timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [1:0] o, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] ehi,
                     input logic [W-1:0] elo, input logic edbz,
                     input string name);
    issue(o, a, b, ehi, elo, edbz, name, 1'b1);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max");
    run(OP_MULT, 32'hFFFF_FFFD, 32'd7,
        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult_m3x7");
    run(OP_MULT, 32'h8000_0000, 32'h8000_0000,
        32'h4000_0000, 32'h0000_0000, 1'b0, "mult_minxmin");
    run(OP_DIV, 32'hFFFF_FFF9, 32'd2,
        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_m7d2");
    run(OP_DIV, 32'd7, 32'hFFFF_FFFE,
        32'h0000_0001, 32'hFFFF_FFFD, 1'b0, "div_7dm2");
    run(OP_DIVU, 32'hFFFF_FFFF, 32'd16,
        32'h0000_000F, 32'h0FFF_FFFF, 1'b0, "divu_big");
    run(OP_DIVU, 32'd100, 32'd0,
        32'd100, 32'hFFFF_FFFF, 1'b1, "divu_by0");
    run(OP_DIV, 32'hFFFF_FFFB, 32'd0,
        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, "div_by0");
    run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
        32'h0000_0000, 32'h8000_0000, 1'b0, "div_ovf");

    mthi_en = 1'b1;
    wr_data = 32'h1234;
    @(posedge clk);
    #1 mthi_en = 1'b0;
    @(negedge clk);
    chk("mthi", 64'(hi), 64'h1234);
    chk("mthi_lo_kept", 64'(lo), 64'h8000_0000);

    mthi_en = 1'b1;
    mtlo_en = 1'b1;
    wr_data = 32'hCAFE;
    @(posedge clk);
    #1 mthi_en = 1'b0;
    mtlo_en = 1'b0;
    @(negedge clk);
    chk("mt_both", {hi, lo}, {32'hCAFE, 32'hCAFE});

    mtlo_en = 1'b1;
    wr_data = 32'hBEEF;
    issue(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, "mt_start_prio", 1'b1);
    mtlo_en = 1'b0;
    @(negedge clk);
    chk("start_beats_mtlo", 64'(lo), 64'hCAFE);
    repeat (5) @(negedge clk);
    mtlo_en = 1'b1;
    start   = 1'b1;
    op      = OP_DIVU;
    wr_data = 32'hDEAD;
    @(negedge clk);
    mtlo_en = 1'b0;
    start   = 1'b0;
    @(negedge clk);
    chk("mt_while_busy", {hi, lo}, {32'hCAFE, 32'hCAFE});
    drain();
    repeat (3) @(negedge clk);
    chk("start_while_busy_idle", 64'(busy), 64'd0);

    issue(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, "b2b_first", 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 60);
    if (!done) chk("b2b_done_timeout", 64'(done), 64'd1);
    issue(OP_MULTU, 32'd4, 32'd5, 32'd0, 32'd20, 1'b0, "b2b_second", 1'b1);
    drain();

    mthi_en = 1'b1;
    wr_data = 32'h55;
    @(posedge clk);
    #1 mthi_en = 1'b0;
    @(negedge clk);
    issue(OP_MULTU, 32'd7, 32'd9, 32'd0, 32'd0, 1'b0, "aborted", 1'b0);
    repeat (11) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_dbz", 64'(div_by_zero), 64'd0);
    chk("midrst_hilo", {hi, lo}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_no_done_later", {hi, lo}, 64'd0);
    run(OP_MULTU, 32'd7, 32'd9, 32'd0, 32'd63, 1'b0, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
